inst_rom_ctrl: RTL

- Instruction-memory responder for the CPU core's fetch port.
- Accepts fetch requests (chip-enable plus byte address) and returns the addressed 32-bit instruction word through a registered read.
- Contains a byte-serial loader (the writer) that fills the word array from address 0 before or between runs.
- Sits beside the core at top level; the loader side is driven by a boot/UART loader or the testbench.

---
 rtl/inst_rom_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/inst_rom_ctrl.sv
// inst_rom_ctrl: instruction memory for the core fetch port, with a byte-serial
// big-endian loader that fills the word array from address 0.
// Ports:
//   clk, rst (async, active-low)
//   rom_ce_i / rom_addr_i     : fetch request (byte address)
//   rom_data_o / rom_valid_o / rom_err_o : registered fetch response, 1-cycle latency
//   load_start_i / load_valid_i / load_byte_i / load_done_i : loader stream
//   load_busy_o  : loader active (LOAD or FLUSH)
//   load_words_o : words written by the last/current load
//   load_ovf_o   : sticky, bytes arrived with the array full
module inst_rom_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rom_ce_i,
    input  logic [ADDR_W-1:0]  rom_addr_i,
    output logic [DATA_W-1:0]  rom_data_o,
    output logic               rom_valid_o,
    output logic               rom_err_o,
    input  logic               load_start_i,
    input  logic               load_valid_i,
    input  logic [7:0]         load_byte_i,
    input  logic               load_done_i,
    output logic               load_busy_o,
    output logic [DEPTH_W:0]   load_words_o,
    output logic               load_ovf_o
);

    localparam int unsigned WORDS_W   = DEPTH_W + 1;
    localparam int unsigned MEM_WORDS = 1 << DEPTH_W;
    localparam int unsigned ASM_W     = DATA_W - 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    logic [1:0]          r_cnt;
    logic [ASM_W-1:0]    r_asm;
    logic [WORDS_W-1:0]  r_words;
    logic                r_ovf;
    logic                r_busy;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [0:MEM_WORDS-1];

    state_t              w_state_nxt;
    logic [1:0]          w_cnt_nxt;
    logic [ASM_W-1:0]    w_asm_nxt;
    logic [WORDS_W-1:0]  w_words_nxt;
    logic                w_ovf_nxt;
    logic                w_commit;
    logic                w_full;
    logic                w_we;
    logic [DATA_W-1:0]   w_wdata;
    logic [ADDR_W-1:0]   w_addr_hi;
    logic [DEPTH_W-1:0]  w_idx;
    logic                w_err;

    // Fetch decode: word index, misalignment and out-of-range detection
    assign w_addr_hi = rom_addr_i >> (DEPTH_W + 2);
    assign w_idx     = rom_addr_i[DEPTH_W+1:2];
    assign w_err     = (rom_addr_i[1:0] != 2'b00) || (w_addr_hi != '0);
    assign w_full    = (r_words == WORDS_W'(MEM_WORDS));

    // Loader next-state, byte assembly and word commit
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_asm_nxt   = r_asm;
        w_words_nxt = r_words;
        w_ovf_nxt   = r_ovf;
        w_commit    = 1'b0;
        w_we        = 1'b0;
        w_wdata     = '0;

        case (r_state)
            ST_RUN: begin
                if (load_start_i) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = 2'd0;
                    w_asm_nxt   = '0;
                    w_words_nxt = '0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (load_start_i) begin
                    w_cnt_nxt   = 2'd0;
                    w_asm_nxt   = '0;
                    w_words_nxt = '0;
                    w_ovf_nxt   = 1'b0;
                end else begin
                    if (load_valid_i) begin
                        case (r_cnt)
                            2'd0: w_asm_nxt[ASM_W-1:ASM_W-8]  = load_byte_i;
                            2'd1: w_asm_nxt[ASM_W-9:ASM_W-16] = load_byte_i;
                            2'd2: w_asm_nxt[ASM_W-17:0]       = load_byte_i;
                            default: begin
                                w_commit  = 1'b1;
                                w_wdata   = {r_asm, load_byte_i};
                                w_asm_nxt = '0;
                            end
                        endcase
                        w_cnt_nxt = r_cnt + 2'd1;
                    end
                    // done sees the byte count after this cycle's byte
                    if (load_done_i) begin
                        w_state_nxt = (w_cnt_nxt == 2'd0) ? ST_RUN : ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (load_start_i) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = 2'd0;
                    w_asm_nxt   = '0;
                    w_words_nxt = '0;
                    w_ovf_nxt   = 1'b0;
                end else begin
                    // unfilled low bytes are already zero in the assembly register
                    w_commit    = 1'b1;
                    w_wdata     = {r_asm, 8'h00};
                    w_cnt_nxt   = 2'd0;
                    w_asm_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase

        // completed word is dropped once the array is full
        if (w_commit) begin
            if (w_full) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_we        = 1'b1;
                w_words_nxt = r_words + WORDS_W'(1);
            end
        end
    end

    // State, loader registers and fetch response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
            r_asm   <= '0;
            r_words <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_asm   <= w_asm_nxt;
            r_words <= w_words_nxt;
            r_ovf   <= w_ovf_nxt;
            r_busy  <= (w_state_nxt != ST_RUN);
            if ((r_state == ST_RUN) && rom_ce_i) begin
                r_valid <= 1'b1;
                r_err   <= w_err;
                r_data  <= w_err ? '0 : r_mem[w_idx];
            end else begin
                r_valid <= 1'b0;
                r_err   <= 1'b0;
                r_data  <= '0;
            end
        end
    end

    // Word array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_words[DEPTH_W-1:0]] <= w_wdata;
        end
    end

    assign rom_data_o   = r_data;
    assign rom_valid_o  = r_valid;
    assign rom_err_o    = r_err;
    assign load_busy_o  = r_busy;
    assign load_words_o = r_words;
    assign load_ovf_o   = r_ovf;

endmodule
